// File: rtl/cond_flag_unit.sv
// NZCV flag register and ARM condition evaluator for the execute stage.
// Commits ALU / logical / MSR flag results and registers the execute-enable toward writeback.
module cond_flag_unit #(
  parameter logic [3:0] RESET_NZCV = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic       stall,
  input  logic       flush,
  input  logic [3:0] cond,
  input  logic [3:0] alu_op,
  input  logic       set_flags,
  input  logic [3:0] alu_nzcv,
  input  logic       shift_c,
  input  logic       msr_we,
  input  logic [3:0] msr_nzcv,
  output logic [3:0] nzcv,
  output logic       c_in,
  output logic       ex_pass,
  output logic       wb_exec
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef enum logic [1:0] {
    UPD_HOLD    = 2'd0,
    UPD_MSR     = 2'd1,
    UPD_ARITH   = 2'd2,
    UPD_LOGICAL = 2'd3
  } upd_e;

  logic [3:0] nzcv_q;
  logic [3:0] nzcv_d;
  logic       wb_exec_q;
  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic       op_arith;
  logic       commit;
  cond_e      cond_code;
  upd_e       upd_sel;

  assign cond_code = cond_e'(cond);
  assign flag_n    = nzcv_q[3];
  assign flag_z    = nzcv_q[2];
  assign flag_c    = nzcv_q[1];
  assign flag_v    = nzcv_q[0];

  // Condition evaluation reads only the register, so a flag result is seen one cycle later.
  always_comb begin
    ex_pass = 1'b0;
    case (cond_code)
      COND_EQ: ex_pass = flag_z;
      COND_NE: ex_pass = ~flag_z;
      COND_CS: ex_pass = flag_c;
      COND_CC: ex_pass = ~flag_c;
      COND_MI: ex_pass = flag_n;
      COND_PL: ex_pass = ~flag_n;
      COND_VS: ex_pass = flag_v;
      COND_VC: ex_pass = ~flag_v;
      COND_HI: ex_pass = flag_c & ~flag_z;
      COND_LS: ex_pass = ~flag_c | flag_z;
      COND_GE: ex_pass = (flag_n == flag_v);
      COND_LT: ex_pass = (flag_n != flag_v);
      COND_GT: ex_pass = ~flag_z & (flag_n == flag_v);
      COND_LE: ex_pass = flag_z | (flag_n != flag_v);
      COND_AL: ex_pass = 1'b1;
      COND_NV: ex_pass = 1'b0;
      default: ex_pass = 1'b0;
    endcase
  end

  always_comb begin
    op_arith = 1'b0;
    case (alu_op)
      4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1010, 4'b1011: op_arith = 1'b1;
      default:                            op_arith = 1'b0;
    endcase
  end

  assign commit = ex_valid & ex_pass & ~stall & ~flush;

  always_comb begin
    upd_sel = UPD_HOLD;
    if (commit) begin
      if (msr_we)
        upd_sel = UPD_MSR;
      else if (set_flags && op_arith)
        upd_sel = UPD_ARITH;
      else if (set_flags)
        upd_sel = UPD_LOGICAL;
    end
  end

  always_comb begin
    nzcv_d = nzcv_q;
    case (upd_sel)
      UPD_MSR:     nzcv_d = msr_nzcv;
      UPD_ARITH:   nzcv_d = alu_nzcv;
      UPD_LOGICAL: nzcv_d = {alu_nzcv[3:2], shift_c, nzcv_q[0]};
      default:     nzcv_d = nzcv_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzcv_q    <= RESET_NZCV;
      wb_exec_q <= 1'b0;
    end else begin
      nzcv_q <= nzcv_d;
      // Stall wins over the load, so a stalled flush leaves wb_exec untouched.
      if (!stall)
        wb_exec_q <= commit;
    end
  end

  assign nzcv    = nzcv_q;
  assign c_in    = nzcv_q[1];
  assign wb_exec = wb_exec_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: stimulus queues expected values tagged with the
// cycle they become due; a negedge monitor pops and compares them.
module tb_cond_flag_unit;

  localparam logic [3:0] RST_VAL = 4'b0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid;
  logic       stall;
  logic       flush;
  logic [3:0] cond;
  logic [3:0] alu_op;
  logic       set_flags;
  logic [3:0] alu_nzcv;
  logic       shift_c;
  logic       msr_we;
  logic [3:0] msr_nzcv;
  logic [3:0] nzcv;
  logic       c_in;
  logic       ex_pass;
  logic       wb_exec;

  cond_flag_unit #(.RESET_NZCV(RST_VAL)) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .stall    (stall),
    .flush    (flush),
    .cond     (cond),
    .alu_op   (alu_op),
    .set_flags(set_flags),
    .alu_nzcv (alu_nzcv),
    .shift_c  (shift_c),
    .msr_we   (msr_we),
    .msr_nzcv (msr_nzcv),
    .nzcv     (nzcv),
    .c_in     (c_in),
    .ex_pass  (ex_pass),
    .wb_exec  (wb_exec)
  );

  always #5 clk = ~clk;

  typedef enum int unsigned { F_NZCV, F_WB, F_PASS, F_CIN } field_e;
  typedef struct {
    int          due;
    field_e      fld;
    logic [3:0]  val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] sample(input field_e f);
    case (f)
      F_NZCV:  return nzcv;
      F_WB:    return {3'b000, wb_exec};
      F_PASS:  return {3'b000, ex_pass};
      default: return {3'b000, c_in};
    endcase
  endfunction

  // Monitor: compare everything that has come due by this cycle.
  always @(negedge clk) begin
    exp_t keep[$];
    logic [3:0] act;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due <= cyc) begin
        act = sample(sb[i].fld);
        checks = checks + 1;
        if (act !== sb[i].val) begin
          errors = errors + 1;
          $display("FAIL %s cyc=%0d actual=%b required=%b", sb[i].name, cyc, act, sb[i].val);
        end
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic expect_at(input int ofs, input field_e f, input logic [3:0] v, input string nm);
    exp_t e;
    e.due = cyc + ofs; e.fld = f; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; stall = 1'b0; flush = 1'b0; cond = 4'b1110; alu_op = 4'b0000;
    set_flags = 1'b0; alu_nzcv = 4'b0000; shift_c = 1'b0; msr_we = 1'b0; msr_nzcv = 4'b0000;
  endtask

  task automatic issue(input logic [3:0] cd, input logic [3:0] op, input logic sf,
                       input logic [3:0] an, input logic sc);
    ex_valid = 1'b1; cond = cd; alu_op = op; set_flags = sf; alu_nzcv = an; shift_c = sc;
    msr_we = 1'b0;
  endtask

  task automatic load_flags(input logic [3:0] v);
    idle();
    ex_valid = 1'b1; cond = 4'b1110; msr_we = 1'b1; msr_nzcv = v;
    tick();
    idle();
  endtask

  function automatic logic ref_pass(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    expect_at(0, F_NZCV, RST_VAL, "reset_nzcv");
    expect_at(0, F_WB, 4'd0, "reset_wb");
    expect_at(0, F_CIN, {3'b000, RST_VAL[1]}, "reset_cin");

    // Reset and EQ
    cond = 4'b0000;
    expect_at(0, F_PASS, 4'd0, "eq_after_reset");
    tick();
    cond = 4'b1110;
    expect_at(0, F_PASS, 4'd1, "al_after_reset");
    issue(4'b1110, 4'b1010, 1'b1, 4'b0100, 1'b0);
    tick();
    expect_at(0, F_NZCV, 4'b0100, "cmp_nzcv");
    expect_at(0, F_WB, 4'd1, "cmp_wb");
    idle();
    cond = 4'b0000;
    expect_at(0, F_PASS, 4'd1, "eq_after_cmp");
    tick();

    // Logical carry: C from shifter, V kept
    load_flags(4'b0011);
    expect_at(0, F_NZCV, 4'b0011, "preload_0011");
    expect_at(0, F_CIN, 4'd1, "preload_cin");
    issue(4'b1110, 4'b1101, 1'b1, 4'b1000, 1'b0);
    tick();
    expect_at(0, F_NZCV, 4'b1001, "logical_nzcv");
    expect_at(0, F_CIN, 4'd0, "logical_cin");
    issue(4'b1110, 4'b1101, 1'b0, 4'b0100, 1'b1);
    tick();
    expect_at(0, F_NZCV, 4'b1001, "no_s_hold");
    expect_at(0, F_WB, 4'd1, "no_s_wb");

    // Failed and NV conditions
    load_flags(4'b0000);
    issue(4'b0000, 4'b0100, 1'b1, 4'b1111, 1'b0);
    expect_at(0, F_PASS, 4'd0, "eq_fail_pass");
    tick();
    expect_at(0, F_NZCV, 4'b0000, "eq_fail_nzcv");
    expect_at(0, F_WB, 4'd0, "eq_fail_wb");
    issue(4'b1111, 4'b0100, 1'b1, 4'b1111, 1'b0);
    tick();
    expect_at(0, F_NZCV, 4'b0000, "nv_nzcv");
    expect_at(0, F_WB, 4'd0, "nv_wb");

    // Stall for 3 cycles then release
    issue(4'b1110, 4'b0100, 1'b1, 4'b0110, 1'b0);
    stall = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      expect_at(0, F_NZCV, 4'b0000, "stall_nzcv");
      expect_at(0, F_WB, 4'd0, "stall_wb");
    end
    stall = 1'b0;
    tick();
    expect_at(0, F_NZCV, 4'b0110, "release_nzcv");
    expect_at(0, F_WB, 4'd1, "release_wb");

    // Flush alone
    issue(4'b1110, 4'b0100, 1'b1, 4'b1001, 1'b0);
    flush = 1'b1;
    tick();
    expect_at(0, F_NZCV, 4'b0110, "flush_nzcv");
    expect_at(0, F_WB, 4'd0, "flush_wb");

    // Stall+flush: wb_exec holds its prior 1
    flush = 1'b0;
    issue(4'b1110, 4'b0100, 1'b1, 4'b0110, 1'b0);
    tick();
    expect_at(0, F_WB, 4'd1, "pre_sf_wb");
    issue(4'b1110, 4'b0100, 1'b1, 4'b1001, 1'b0);
    stall = 1'b1; flush = 1'b1;
    tick();
    expect_at(0, F_NZCV, 4'b0110, "stall_flush_nzcv");
    expect_at(0, F_WB, 4'd1, "stall_flush_wb");
    stall = 1'b0;
    tick();
    expect_at(0, F_NZCV, 4'b0110, "flush_release_nzcv");
    expect_at(0, F_WB, 4'd0, "flush_release_wb");

    // MSR beats set_flags
    idle();
    issue(4'b1110, 4'b0100, 1'b1, 4'b0101, 1'b0);
    msr_we = 1'b1; msr_nzcv = 4'b1010;
    tick();
    expect_at(0, F_NZCV, 4'b1010, "msr_nzcv");
    expect_at(0, F_CIN, 4'd1, "msr_cin");

    // Full condition sweep
    for (int unsigned f = 0; f < 16; f++) begin
      load_flags(4'(f));
      expect_at(0, F_NZCV, 4'(f), "sweep_load");
      for (int unsigned c = 0; c < 16; c++) begin
        cond = 4'(c);
        expect_at(0, F_PASS, {3'b000, ref_pass(4'(f), 4'(c))}, $sformatf("sweep_f%0d_c%0d", f, c));
        tick();
      end
    end

    // Async reset between edges discards the pending update
    issue(4'b1110, 4'b0100, 1'b1, 4'b1111, 1'b0);
    tick();
    expect_at(0, F_NZCV, 4'b1111, "pre_rst_nzcv");
    expect_at(0, F_WB, 4'd1, "pre_rst_wb");
    tick();
    rst = 1'b1;
    expect_at(0, F_NZCV, RST_VAL, "async_rst_nzcv");
    expect_at(0, F_WB, 4'd0, "async_rst_wb");
    tick();
    expect_at(0, F_NZCV, RST_VAL, "rst_held_nzcv");
    rst = 1'b0;
    issue(4'b1110, 4'b0100, 1'b1, 4'b1100, 1'b0);
    tick();
    expect_at(0, F_NZCV, 4'b1100, "post_rst_nzcv");
    expect_at(0, F_WB, 4'd1, "post_rst_wb");
    idle();

    // Drain the scoreboard with a bounded wait
    for (int unsigned w = 0; w < 20 && sb.size() != 0; w++) tick();
    if (sb.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cond_flag_unit.md
# cond_flag_unit

Consumer side of the ALU flag interface. Holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field of the instruction in execute against those flags. Commits the ALU's `nzcv` result, or a logical-op variant of it, into the register. Feeds the registered carry back to the ALU as `c_in` and emits a registered execute-enable toward writeback.

## Interface

Parameters:
- `RESET_NZCV`, default 4'b0000: flag register value on reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `ex_valid` in 1: an instruction occupies execute this cycle.
- `stall` in 1: execute is held; no state changes except reset.
- `flush` in 1: squash the execute instruction; no flag update, and `wb_exec` goes to 0.
- `cond` in 4: ARM condition field of the execute instruction.
- `alu_op` in 4: ALU opcode of the execute instruction.
- `set_flags` in 1: S bit; the instruction may update flags.
- `alu_nzcv` in 4: {N,Z,C,V} from the ALU this cycle.
- `shift_c` in 1: barrel-shifter carry-out, used as C for logical ops.
- `msr_we` in 1: flag write from an MSR-type instruction in execute.
- `msr_nzcv` in 4: flag value written when `msr_we` is set.
- `nzcv` out 4: current flag register {N,Z,C,V}.
- `c_in` out 1: equals `nzcv[1]`; drives the ALU carry input.
- `ex_pass` out 1: combinational; the condition passes against the current `nzcv`.
- `wb_exec` out 1: registered; the instruction executed and not squashed.

## Operation

- Condition decode, using N,Z,C,V from the register:
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0100 MI: N.
  - 0101 PL: !N.
  - 0110 VS: V.
  - 0111 VC: !V.
  - 1000 HI: C&!Z.
  - 1001 LS: !C|Z.
  - 1010 GE: N==V.
  - 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V).
  - 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111 NV: 0.
- `commit` = `ex_valid` & `ex_pass` & !`stall` & !`flush`.
- Flag update on commit, in priority order:
  1. `msr_we`=1: `nzcv` <= `msr_nzcv`, whatever `set_flags` is.
  2. else `set_flags`=1 and `alu_op` is arithmetic (0010–0111, 1010, 1011): `nzcv` <= `alu_nzcv`.
  3. else `set_flags`=1 and `alu_op` is logical (0000, 0001, 1000, 1001, 1100–1111): N,Z <= `alu_nzcv[3:2]`, C <= `shift_c`, V held.
  4. else: hold.
- A failed condition, stall, flush or !`ex_valid` never changes `nzcv`.
- `wb_exec` <= `commit` whenever `stall`=0. While `stall`=1, `wb_exec` holds its value.
- `ex_pass` is meaningful only when `ex_valid`=1, but is always driven.

## Timing

- Reset: `nzcv` = `RESET_NZCV`, so `c_in` = `RESET_NZCV[1]`; `wb_exec` = 0. Reset takes effect immediately, independent of `clk`.
- Reset asserted mid-operation discards any pending update. The first edge after deassertion behaves as normal.
- Flag latency is 1 cycle. An instruction committing in cycle t makes its flags visible on `nzcv`, `c_in` and in `ex_pass` evaluation in cycle t+1. Back-to-back dependent instructions (CMP then BEQ, ADDS then ADC) therefore need no bypass and no bubble.
- `ex_pass` is purely combinational from `cond` and the register. It has no path from `alu_nzcv`.
- `wb_exec` latency is 1 cycle after the commit edge.
- Stall: with `stall`=1 for k cycles, `nzcv` and `wb_exec` are frozen for k edges. The instruction commits on the first edge with `stall`=0.
- Simultaneous `stall` and `flush`: `flush` suppresses the flag update. `wb_exec` still holds, because `stall` has priority over the `wb_exec` load.

## Test plan

- Reset and EQ: reset with `RESET_NZCV`=0; `cond`=0000 gives `ex_pass`=0 and `cond`=1110 gives `ex_pass`=1. Then commit `alu_op`=1010, `set_flags`=1, `alu_nzcv`=0100 → next cycle `nzcv`=0100 and EQ passes.
- Logical carry: `nzcv`=0011; commit `alu_op`=1101, `set_flags`=1, `alu_nzcv`=1000, `shift_c`=0 → `nzcv`=1001 (V kept, C from shifter).
- Failed and NV conditions: `nzcv`=0000, `cond`=0000, `set_flags`=1, `alu_nzcv`=1111 → `nzcv` stays 0000 and `wb_exec`=0 next cycle. Repeat with `cond`=1111 → same result.
- Stall and flush: hold `stall`=1 for 3 cycles during a passing ADDS with `alu_nzcv`=0110 → `nzcv` unchanged for 3 cycles, then 0110 one cycle after release. Repeat with `flush`=1 → `nzcv` never changes and `wb_exec`=0.
- MSR priority: `msr_we`=1, `msr_nzcv`=1010, `set_flags`=1, `alu_nzcv`=0101, `cond`=1110 → `nzcv`=1010 and `c_in`=1.
- Full cond sweep plus async reset: for all 16 `nzcv` values × 16 `cond` values, compare `ex_pass` against the decode table. Then assert `rst` between clock edges → `nzcv`=`RESET_NZCV` and `wb_exec`=0 before the next edge.
